pe_inst_issue: RTL and testbench
================================

Name: pe_inst_issue

Overview:
- Per-PE instruction sequencer for the SCGRA array; the initiator side of the PE's ALU.
- On Start, fetches Inst_Count instruction words from the PE context memory, one per cycle.
- For each instruction: decodes it, reads three operands from the PE data memory, and drives the ALU opcode and operands.
- Writes the ALU result back to data memory after the fixed ALU latency, then pulses Done.

Parameters:
- DWIDTH, 32, data and ALU operand width.
- AWIDTH, 8, data memory address width.
- IAWIDTH, 10, context memory address width.
- IWIDTH, 37, instruction width = 1 + 4 + 4*AWIDTH.
- ALU_LAT, 3, cycles from ALU operand input to ALU Data_Out valid; identical for all opcodes.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse; begin execution; ignored unless IDLE.
- Inst_Count  in  IAWIDTH  number of instructions to run; sampled on Start.
- Busy  out  1  high in RUN and DRAIN.
- Done  out  1  one-cycle completion pulse.
- Inst_Rd_Addr  out  IAWIDTH  context memory address; read data arrives 1 cycle later.
- Inst_Rd_Data  in  IWIDTH  instruction word.
- Mem_Rd_Addr0/1/2  out  AWIDTH each  data memory read addresses; read data arrives 1 cycle later.
- Mem_Rd_Data0/1/2  in  DWIDTH each  operand read data.
- ALU_OP_Sel  out  4  opcode to ALU.
- ALU_Data_In0/1/2  out  DWIDTH each  operands to ALU.
- ALU_Data_Out  in  DWIDTH  ALU result.
- Mem_Wr_En  out  1  data memory write strobe.
- Mem_Wr_Addr  out  AWIDTH  write-back address.
- Mem_Wr_Data  out  DWIDTH  write-back data.

Behaviour:
- Instruction fields, MSB first: Wr_Flag[IWIDTH-1], Op[IWIDTH-2 -: 4], Dst, Src2, Src1, Src0 (AWIDTH each, Src0 at LSBs).
- Reset (asynchronous, any time, including mid-run):
  - State = IDLE; PC, all pipeline registers and valid bits cleared.
  - All outputs 0: Busy, Done, Mem_Wr_En, ALU_OP_Sel, all addresses.
  - In-flight instructions are discarded with no write.
- IDLE:
  - Start with Inst_Count=0 -> Done=1 the next cycle; state stays IDLE.
  - Start with Inst_Count>0 -> PC=0, latch count, enter RUN.
- RUN:
  - Each cycle: Inst_Rd_Addr=PC; issue-valid bit set; PC increments.
  - After issuing address Inst_Count-1 -> enter DRAIN.
  - Start is ignored.
- Pipeline, with issue at cycle t:
  - t+1: decode Inst_Rd_Data; drive Mem_Rd_Addr0/1/2 = Src0/1/2 (registered); register Op, Dst, Wr_Flag.
  - t+2: ALU_Data_InN = Mem_Rd_DataN (direct); ALU_OP_Sel = registered Op.
  - t+2+ALU_LAT: Mem_Wr_En = Wr_Flag & valid; Mem_Wr_Addr = Dst; Mem_Wr_Data = ALU_Data_Out.
  - Dst and Wr_Flag are carried through a delay line of depth ALU_LAT.
  - Throughput is one instruction per cycle; there are no stalls.
- Hazards:
  - A read issued in the same cycle as a write to the same address gets the old data. Memory defines this read-during-write behaviour; the block does not forward.
  - The compiler guarantees dependency distance >= 3+ALU_LAT; the hardware does not check it.
- DRAIN:
  - Counts 2+ALU_LAT cycles after the last issue; final write occurs in its last cycle.
  - Next cycle: Done=1 for one cycle; state = IDLE; Busy=0.
- Bubbles: when no valid instruction is in a stage, ALU_OP_Sel=0. Mem_Wr_En is never asserted for bubbles.
- Inst_Count is IAWIDTH wide; the maximum 2^IAWIDTH-1 must not wrap PC.

Decomposition:
- Shared package pe_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_MULADD=3, OP_AND=4, OP_SHL=6, OP_PHI=7, OP_GT=8, OP_LET=9.
  - Instruction field offsets/widths.
  - State encoding IDLE/RUN/DRAIN.
- One sub-module pe_delay_line:
  - Parameters WIDTH, DEPTH.
  - Async active-high reset; reset value 0.
  - Carries {valid, Wr_Flag, Dst} across ALU_LAT.

Test Plan:
1. Single ADD:
   - Setup: mem[1]=5, mem[2]=7; inst0 = {1,OP_ADD,Dst=3,0,2,1}; Inst_Count=1; pulse Start at cycle 0.
   - Expect: Inst_Rd_Addr=0 at cycle 1; ALU_OP_Sel=0 and ALU_Data_In0=5, ALU_Data_In1=7 at cycle 3.
   - Expect: Mem_Wr_En with addr 3, data 12 at cycle 3+ALU_LAT; Done at cycle 4+ALU_LAT.
2. Back-to-back run:
   - Setup: 8 independent instructions.
   - Expect: Inst_Rd_Addr 0..7 on consecutive cycles; 8 consecutive write strobes in order; Busy high throughout; exactly one Done.
3. Wr_Flag=0 instruction (compare discarded):
   - Expect: ALU sees the operands, no Mem_Wr_En pulse, Done timing unchanged.
4. Inst_Count=0:
   - Expect: Done one cycle after Start; Busy never asserts; no memory reads.
5. Start pulsed during RUN:
   - Expect: ignored; PC sequence and Done count unaffected.
6. Reset asserted at the 4th RUN cycle:
   - Expect: all outputs 0 immediately; no further writes.
   - After deassert, a new Start runs cleanly from PC=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE instruction sequencer: opcodes, instruction field layout
// and sequencer state encoding.
package pe_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_MULADD = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_SHL    = 4'd6;
  localparam logic [3:0] OP_PHI    = 4'd7;
  localparam logic [3:0] OP_GT     = 4'd8;
  localparam logic [3:0] OP_LET    = 4'd9;

  localparam int unsigned OpW = 4;

  // Layout, LSB first: Src0, Src1, Src2, Dst (aw bits each), Op, Wr_Flag.
  function automatic int unsigned src_lsb(input int unsigned idx, input int unsigned aw);
    return idx * aw;
  endfunction

  function automatic int unsigned dst_lsb(input int unsigned aw);
    return 3 * aw;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned aw);
    return 4 * aw;
  endfunction

  function automatic int unsigned wr_bit(input int unsigned aw);
    return 4 * aw + OpW;
  endfunction

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/pe_delay_line.sv
// Fixed-depth shift register; output equals input delayed by DEPTH clock cycles.
module pe_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_inst_issue.sv
// Per-PE instruction sequencer: fetches Inst_Count instructions, reads operands, drives the
// ALU and writes results back after the fixed ALU latency. One instruction per cycle.
module pe_inst_issue
  import pe_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned IAWIDTH = 10,
  parameter int unsigned IWIDTH  = 37,
  parameter int unsigned ALU_LAT = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [IAWIDTH-1:0] Inst_Count,
  output logic               Busy,
  output logic               Done,
  output logic [IAWIDTH-1:0] Inst_Rd_Addr,
  input  logic [IWIDTH-1:0]  Inst_Rd_Data,
  output logic [AWIDTH-1:0]  Mem_Rd_Addr0,
  output logic [AWIDTH-1:0]  Mem_Rd_Addr1,
  output logic [AWIDTH-1:0]  Mem_Rd_Addr2,
  input  logic [DWIDTH-1:0]  Mem_Rd_Data0,
  input  logic [DWIDTH-1:0]  Mem_Rd_Data1,
  input  logic [DWIDTH-1:0]  Mem_Rd_Data2,
  output logic [3:0]         ALU_OP_Sel,
  output logic [DWIDTH-1:0]  ALU_Data_In0,
  output logic [DWIDTH-1:0]  ALU_Data_In1,
  output logic [DWIDTH-1:0]  ALU_Data_In2,
  input  logic [DWIDTH-1:0]  ALU_Data_Out,
  output logic               Mem_Wr_En,
  output logic [AWIDTH-1:0]  Mem_Wr_Addr,
  output logic [DWIDTH-1:0]  Mem_Wr_Data
);

  localparam int unsigned Src0Lsb = src_lsb(0, AWIDTH);
  localparam int unsigned Src1Lsb = src_lsb(1, AWIDTH);
  localparam int unsigned Src2Lsb = src_lsb(2, AWIDTH);
  localparam int unsigned DstLsb  = dst_lsb(AWIDTH);
  localparam int unsigned OpLsb   = op_lsb(AWIDTH);
  localparam int unsigned WrBit   = wr_bit(AWIDTH);
  localparam int unsigned CntW    = $clog2(ALU_LAT + 3);
  localparam logic [CntW-1:0] DrainLast = CntW'(ALU_LAT + 1);
  localparam int unsigned DlW     = AWIDTH + 2;

  state_e              state_q, state_d;
  logic [IAWIDTH-1:0]  pc_q, pc_d;
  logic [IAWIDTH-1:0]  count_q, count_d;
  logic [CntW-1:0]     drain_q, drain_d;
  logic                done_q, done_d;

  // Stage 1: instruction word on Inst_Rd_Data. Stage 2: operands at the ALU.
  logic                iss_vld_q, iss_vld_d;
  logic                ex_vld_q, ex_vld_d;
  logic [OpW-1:0]      op_q, op_d;
  logic [AWIDTH-1:0]   dst_q, dst_d;
  logic                wr_q, wr_d;

  logic [DlW-1:0]      wb_q;
  logic                wb_vld;
  logic                wb_wr;
  logic [AWIDTH-1:0]   wb_dst;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (Inst_Count == '0) begin
            done_d = 1'b1;
          end else begin
            pc_d    = '0;
            count_d = Inst_Count;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Holding PC on the last issue keeps a maximal count from wrapping it.
        if (pc_q == count_q - IAWIDTH'(1)) begin
          drain_d = '0;
          state_d = StDrain;
        end else begin
          pc_d = pc_q + IAWIDTH'(1);
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          drain_d = drain_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    iss_vld_d = (state_q == StRun);
    ex_vld_d  = iss_vld_q;
    op_d      = iss_vld_q ? Inst_Rd_Data[OpLsb +: OpW] : '0;
    dst_d     = iss_vld_q ? Inst_Rd_Data[DstLsb +: AWIDTH] : '0;
    wr_d      = iss_vld_q & Inst_Rd_Data[WrBit];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      count_q   <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
      iss_vld_q <= 1'b0;
      ex_vld_q  <= 1'b0;
      op_q      <= '0;
      dst_q     <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      iss_vld_q <= iss_vld_d;
      ex_vld_q  <= ex_vld_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      wr_q      <= wr_d;
    end
  end

  pe_delay_line #(
    .WIDTH (DlW),
    .DEPTH (ALU_LAT)
  ) u_wb_delay (
    .clk_i (Clk),
    .rst_i (Reset),
    .d_i   ({ex_vld_q, wr_q, dst_q}),
    .q_o   (wb_q)
  );

  assign wb_vld = wb_q[DlW-1];
  assign wb_wr  = wb_q[DlW-2];
  assign wb_dst = wb_q[AWIDTH-1:0];

  always_comb begin
    Busy         = (state_q != StIdle);
    Done         = done_q;
    Inst_Rd_Addr = (state_q == StRun) ? pc_q : '0;
    // Read addresses come straight from the fetched word so operands land one cycle later.
    Mem_Rd_Addr0 = iss_vld_q ? Inst_Rd_Data[Src0Lsb +: AWIDTH] : '0;
    Mem_Rd_Addr1 = iss_vld_q ? Inst_Rd_Data[Src1Lsb +: AWIDTH] : '0;
    Mem_Rd_Addr2 = iss_vld_q ? Inst_Rd_Data[Src2Lsb +: AWIDTH] : '0;
    ALU_OP_Sel   = ex_vld_q ? op_q : '0;
    ALU_Data_In0 = Mem_Rd_Data0;
    ALU_Data_In1 = Mem_Rd_Data1;
    ALU_Data_In2 = Mem_Rd_Data2;
    Mem_Wr_En    = wb_vld & wb_wr;
    Mem_Wr_Addr  = Mem_Wr_En ? wb_dst : '0;
    Mem_Wr_Data  = Mem_Wr_En ? ALU_Data_Out : '0;
  end

endmodule

// File: tb/tb_pe_inst_issue.sv
// Bench for pe_inst_issue: memory/ALU environment models, sequential reference model and a
// write-back scoreboard checked by an independent monitor.
module tb_pe_inst_issue;
  import pe_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int IAW = 10;
  localparam int IW  = 37;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           Start = 1'b0;
  logic [IAW-1:0] Inst_Count = '0;
  logic           Busy, Done;
  logic [IAW-1:0] Inst_Rd_Addr;
  logic [IW-1:0]  Inst_Rd_Data;
  logic [AW-1:0]  Mem_Rd_Addr0, Mem_Rd_Addr1, Mem_Rd_Addr2;
  logic [DW-1:0]  Mem_Rd_Data0, Mem_Rd_Data1, Mem_Rd_Data2;
  logic [3:0]     ALU_OP_Sel;
  logic [DW-1:0]  ALU_Data_In0, ALU_Data_In1, ALU_Data_In2, ALU_Data_Out;
  logic           Mem_Wr_En;
  logic [AW-1:0]  Mem_Wr_Addr;
  logic [DW-1:0]  Mem_Wr_Data;

  always #5 clk = ~clk;

  pe_inst_issue #(
    .DWIDTH (DW), .AWIDTH (AW), .IAWIDTH (IAW), .IWIDTH (IW), .ALU_LAT (LAT)
  ) dut (
    .Clk (clk), .Reset (rst), .Start (Start), .Inst_Count (Inst_Count),
    .Busy (Busy), .Done (Done),
    .Inst_Rd_Addr (Inst_Rd_Addr), .Inst_Rd_Data (Inst_Rd_Data),
    .Mem_Rd_Addr0 (Mem_Rd_Addr0), .Mem_Rd_Addr1 (Mem_Rd_Addr1), .Mem_Rd_Addr2 (Mem_Rd_Addr2),
    .Mem_Rd_Data0 (Mem_Rd_Data0), .Mem_Rd_Data1 (Mem_Rd_Data1), .Mem_Rd_Data2 (Mem_Rd_Data2),
    .ALU_OP_Sel (ALU_OP_Sel),
    .ALU_Data_In0 (ALU_Data_In0), .ALU_Data_In1 (ALU_Data_In1), .ALU_Data_In2 (ALU_Data_In2),
    .ALU_Data_Out (ALU_Data_Out),
    .Mem_Wr_En (Mem_Wr_En), .Mem_Wr_Addr (Mem_Wr_Addr), .Mem_Wr_Data (Mem_Wr_Data)
  );

  // Environment: memories with 1-cycle read latency, ALU with LAT-cycle latency.
  logic [DW-1:0] dmem [256];
  logic [IW-1:0] cmem [1024];
  logic [DW-1:0] alu_pipe [LAT];

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] c);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_MUL:    return a * b;
      OP_MULADD: return a * b + c;
      OP_AND:    return a & b;
      OP_SHL:    return a << b[4:0];
      OP_PHI:    return c[0] ? b : a;
      OP_GT:     return (a > b) ? 32'd1 : 32'd0;
      OP_LET:    return (a <= b) ? 32'd1 : 32'd0;
      default:   return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    Inst_Rd_Data <= cmem[Inst_Rd_Addr];
    Mem_Rd_Data0 <= dmem[Mem_Rd_Addr0];
    Mem_Rd_Data1 <= dmem[Mem_Rd_Addr1];
    Mem_Rd_Data2 <= dmem[Mem_Rd_Addr2];
    if (Mem_Wr_En) dmem[Mem_Wr_Addr] <= Mem_Wr_Data;
    alu_pipe[0] <= alu_f(ALU_OP_Sel, ALU_Data_In0, ALU_Data_In1, ALU_Data_In2);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign ALU_Data_Out = alu_pipe[LAT-1];

  // Scoreboard state
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wq[$];
  wr_t exp_w;
  int  checks = 0;
  int  failures = 0;
  int  done_cnt = 0;

  // Program under test and reference-model memory image
  logic [DW-1:0] mm [256];
  logic          p_wr  [64];
  logic [3:0]    p_op  [64];
  logic [AW-1:0] p_dst [64];
  logic [AW-1:0] p_s0  [64];
  logic [AW-1:0] p_s1  [64];
  logic [AW-1:0] p_s2  [64];
  logic [DW-1:0] ea0, ea1, ea2;
  logic [3:0]    ops [9] = '{OP_ADD, OP_SUB, OP_MUL, OP_MULADD, OP_AND, OP_SHL, OP_PHI,
                             OP_GT, OP_LET};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (Mem_Wr_En) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", Mem_Wr_Addr, Mem_Wr_Data);
      end else begin
        exp_w = wq.pop_front();
        if (Mem_Wr_Addr !== exp_w.a || Mem_Wr_Data !== exp_w.d) begin
          failures++;
          $display("FAIL write actual=%0h:%0h required=%0h:%0h", Mem_Wr_Addr, Mem_Wr_Data,
                   exp_w.a, exp_w.d);
        end
      end
    end
    if (Done === 1'b1) done_cnt++;
  end

  task automatic rand_mem();
    for (int i = 0; i < 256; i++) mm[i] = $urandom;
  endtask

  // Sources in 0..127, distinct destinations in 128..255: no intra-program dependencies.
  task automatic rand_prog(input int n, input bit rand_wr);
    int base;
    base = $urandom_range(0, 127);
    for (int i = 0; i < n; i++) begin
      p_op[i]  = ops[$urandom_range(0, 8)];
      p_wr[i]  = rand_wr ? ($urandom_range(0, 3) != 0) : 1'b1;
      p_s0[i]  = 8'($urandom_range(0, 127));
      p_s1[i]  = 8'($urandom_range(0, 127));
      p_s2[i]  = 8'($urandom_range(0, 127));
      p_dst[i] = 8'(128 + ((i * 37 + base) % 128));
    end
  endtask

  task automatic commit(input int n);
    for (int i = 0; i < 256; i++) dmem[i] <= mm[i];
    for (int i = 0; i < n; i++) cmem[i] = {p_wr[i], p_op[i], p_dst[i], p_s2[i], p_s1[i], p_s0[i]};
  endtask

  // Sequential execution of the program; expected write-backs go to the scoreboard.
  task automatic model(input int n);
    logic [DW-1:0] r;
    if (n > 0) begin
      ea0 = mm[p_s0[0]];
      ea1 = mm[p_s1[0]];
      ea2 = mm[p_s2[0]];
    end
    for (int i = 0; i < n; i++) begin
      r = alu_f(p_op[i], mm[p_s0[i]], mm[p_s1[i]], mm[p_s2[i]]);
      if (p_wr[i]) begin
        wq.push_back('{a: p_dst[i], d: r});
        mm[p_dst[i]] = r;
      end
    end
  endtask

  task automatic run_prog(input int n, input bit poke);
    int exp_done;
    int d0;
    logic exp_we;
    exp_done = (n == 0) ? 1 : n + 3 + LAT;
    d0 = done_cnt;
    @(posedge clk); #1;
    Start = 1'b1;
    Inst_Count = IAW'(n);
    for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
      @(posedge clk); #1;
      Start = poke && (cyc == 3);
      if (Start) Inst_Count = IAW'(5);
      @(negedge clk);
      if (cyc <= n) chk("inst_rd_addr", Inst_Rd_Addr, 64'(cyc - 1));
      chk("busy", Busy, (n > 0 && cyc < exp_done));
      chk("done", Done, (cyc == exp_done));
      if (n > 0 && cyc == 3) begin
        chk("alu_op_first", ALU_OP_Sel, p_op[0]);
        chk("alu_in0_first", ALU_Data_In0, ea0);
        chk("alu_in1_first", ALU_Data_In1, ea1);
        chk("alu_in2_first", ALU_Data_In2, ea2);
      end
      if (n > 0 && cyc == n + 3) chk("alu_op_bubble", ALU_OP_Sel, 0);
      exp_we = (n > 0 && cyc >= 3 + LAT && cyc <= n + 2 + LAT) ? p_wr[cyc - 3 - LAT] : 1'b0;
      chk("wr_en_timing", Mem_Wr_En, exp_we);
    end
    Start = 1'b0;
    chk("done_pulses", 64'(done_cnt - d0), 1);
    chk("writes_pending", 64'(wq.size()), 0);
  endtask

  task automatic reset_mid_run();
    rand_mem();
    rand_prog(10, 1'b0);
    commit(10);
    @(posedge clk); #1;
    Start = 1'b1;
    Inst_Count = IAW'(10);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      Start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_wr_en", Mem_Wr_En, 0);
    chk("rst_alu_op", ALU_OP_Sel, 0);
    chk("rst_inst_addr", Inst_Rd_Addr, 0);
    chk("rst_rd_addr", {Mem_Rd_Addr0, Mem_Rd_Addr1, Mem_Rd_Addr2}, 0);
    chk("rst_wr_addr", Mem_Wr_Addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_wr_en", Mem_Wr_En, 0);
    chk("reset_alu_op", ALU_OP_Sel, 0);
    chk("reset_inst_addr", Inst_Rd_Addr, 0);
    rst = 1'b0;

    // Single ADD: mem[1]=5, mem[2]=7 -> mem[3]=12
    rand_mem();
    mm[1] = 32'd5;
    mm[2] = 32'd7;
    p_wr[0] = 1'b1; p_op[0] = OP_ADD; p_dst[0] = 8'd3;
    p_s2[0] = 8'd0; p_s1[0] = 8'd2; p_s0[0] = 8'd1;
    commit(1);
    model(1);
    chk("add_model", {ea0, ea1}, {32'd5, 32'd7});
    run_prog(1, 1'b0);

    // Back-to-back independent instructions
    rand_mem(); rand_prog(8, 1'b0); commit(8); model(8);
    run_prog(8, 1'b0);

    // Compare result discarded
    rand_mem(); rand_prog(1, 1'b0);
    p_op[0] = OP_GT; p_wr[0] = 1'b0;
    commit(1); model(1);
    run_prog(1, 1'b0);

    // Empty program
    run_prog(0, 1'b0);

    // Start pulsed while running
    rand_mem(); rand_prog(12, 1'b1); commit(12); model(12);
    run_prog(12, 1'b1);

    // Reset in the 4th RUN cycle, then a clean run
    reset_mid_run();
    rand_mem(); rand_prog(6, 1'b1); commit(6); model(6);
    run_prog(6, 1'b0);

    // Randomized programs
    for (int k = 0; k < 10; k++) begin
      int n;
      n = $urandom_range(1, 40);
      rand_mem(); rand_prog(n, 1'b1); commit(n); model(n);
      run_prog(n, ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
